// File: rtl/regfile_pkg.sv
// Shared constants, address-width helper and read-mux select type for the register file.
package regfile_pkg;

  localparam int unsigned REGFILE_WIDTH = 32;
  localparam int unsigned REGFILE_DEPTH = 32;

  // Address bits for a given depth; never narrower than one bit.
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Source chosen by a read port for its next output value.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_BYPASS,
    SEL_MEM
  } rd_sel_e;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range check, zero/bypass/memory priority mux, output and valid registers.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = REGFILE_WIDTH,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = addr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wr_legal,
  input  logic [ADDR_W-1:0] address_w,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  data,
  output logic              valid
);

  // One extra bit so a DEPTH equal to 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic             in_range;
  rd_sel_e          sel;
  logic [WIDTH-1:0] rd_value;

  // Pick the value source in priority order: clear/out-of-range/reg0, then bypass, then storage.
  always_comb begin
    in_range = ({1'b0, address} < DEPTH_X);
    sel      = SEL_MEM;
    if (clear || !in_range || (ZERO_REG && (address == '0))) begin
      sel = SEL_ZERO;
    end else if (BYPASS && wr_legal && (address_w == address)) begin
      sel = SEL_BYPASS;
    end
  end

  // Drive the selected source onto the output register input.
  always_comb begin
    rd_value = '0;
    case (sel)
      SEL_ZERO:   rd_value = '0;
      SEL_BYPASS: rd_value = wr_data;
      SEL_MEM:    rd_value = mem_data;
      default:    rd_value = '0;
    endcase
  end

  // Output register updates only on enable; valid follows enable every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= enable;
      if (enable) begin
        data <= rd_value;
      end
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports, synchronous bulk clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = REGFILE_WIDTH,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W  = addr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable_w,
  input  logic [ADDR_W-1:0] address_w,
  input  logic [WIDTH-1:0]  In,
  input  logic              enable_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic              enable_b,
  input  logic [ADDR_W-1:0] address_b,
  output logic [WIDTH-1:0]  OutA,
  output logic [WIDTH-1:0]  OutB,
  output logic              valid_a,
  output logic              valid_b
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_legal;
  logic [WIDTH-1:0] mem_a;
  logic [WIDTH-1:0] mem_b;

  // A write takes effect only for an in-range address that is not the hardwired zero register.
  always_comb begin
    wr_legal = enable_w && ({1'b0, address_w} < DEPTH_X) &&
               !(ZERO_REG && (address_w == '0));
  end

  // Storage: reset and clear zero everything, clear beats a simultaneous write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_legal) begin
      mem[address_w] <= In;
    end
  end

  // Raw array lookups; out-of-range results are discarded by the read ports.
  always_comb begin
    mem_a = mem[address_a];
    mem_b = mem[address_b];
  end

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .enable    (enable_a),
    .address   (address_a),
    .mem_data  (mem_a),
    .wr_legal  (wr_legal),
    .address_w (address_w),
    .wr_data   (In),
    .data      (OutA),
    .valid     (valid_a)
  );

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .enable    (enable_b),
    .address   (address_b),
    .mem_data  (mem_b),
    .wr_legal  (wr_legal),
    .address_w (address_w),
    .wr_data   (In),
    .data      (OutB),
    .valid     (valid_b)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default config and a DEPTH=20, no-zero-reg, no-bypass config share stimulus.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        enable_w = 1'b0;
  logic [4:0]  address_w = '0;
  logic [31:0] In = '0;
  logic        enable_a = 1'b0;
  logic [4:0]  address_a = '0;
  logic        enable_b = 1'b0;
  logic [4:0]  address_b = '0;

  logic [31:0] a0, b0, a1, b1;
  logic        va0, vb0, va1, vb1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_param u_dflt (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .enable_w(enable_w), .address_w(address_w), .In(In),
    .enable_a(enable_a), .address_a(address_a),
    .enable_b(enable_b), .address_b(address_b),
    .OutA(a0), .OutB(b0), .valid_a(va0), .valid_b(vb0)
  );

  regfile_param #(.DEPTH(20), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .enable_w(enable_w), .address_w(address_w), .In(In),
    .enable_a(enable_a), .address_a(address_a),
    .enable_b(enable_b), .address_b(address_b),
    .OutA(a1), .OutB(b1), .valid_a(va1), .valid_b(vb1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [31:0] e_a0 = '0, e_b0 = '0, e_a1 = '0, e_b1 = '0;
  logic        e_va = 1'b0, e_vb = 1'b0;

  function automatic bit legal(input int wa, input int depth, input bit zr);
    return (wa < depth) && !(zr && wa == 0);
  endfunction

  function automatic logic [31:0] pred(input logic [31:0] m [32], input int depth,
                                       input bit zr, input bit byp, input int addr);
    if (clear) return 32'h0;
    if (addr >= depth) return 32'h0;
    if (zr && addr == 0) return 32'h0;
    if (byp && enable_w && int'(address_w) == addr && legal(int'(address_w), depth, zr)) return In;
    return m[addr];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m0[i] <= '0;
        m1[i] <= '0;
      end
      e_a0 <= '0; e_b0 <= '0; e_a1 <= '0; e_b1 <= '0;
      e_va <= 1'b0; e_vb <= 1'b0;
    end else begin
      e_va <= enable_a;
      e_vb <= enable_b;
      if (enable_a) begin
        e_a0 <= pred(m0, 32, 1'b1, 1'b1, int'(address_a));
        e_a1 <= pred(m1, 20, 1'b0, 1'b0, int'(address_a));
      end
      if (enable_b) begin
        e_b0 <= pred(m0, 32, 1'b1, 1'b1, int'(address_b));
        e_b1 <= pred(m1, 20, 1'b0, 1'b0, int'(address_b));
      end
      for (int i = 0; i < 32; i++) begin
        if (clear) begin
          m0[i] <= '0;
          m1[i] <= '0;
        end else if (enable_w && int'(address_w) == i) begin
          if (legal(i, 32, 1'b1)) m0[i] <= In;
          if (legal(i, 20, 1'b0)) m1[i] <= In;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("dflt.OutA", a0, e_a0);
    check("dflt.OutB", b0, e_b0);
    check("dflt.valid_a", 32'(va0), 32'(e_va));
    check("dflt.valid_b", 32'(vb0), 32'(e_vb));
    check("alt.OutA", a1, e_a1);
    check("alt.OutB", b1, e_b1);
    check("alt.valid_a", 32'(va1), 32'(e_va));
    check("alt.valid_b", 32'(vb1), 32'(e_vb));
  end

  // Advance to just after the next falling edge (inputs change here, outputs are settled).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; enable_w = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    enable_a = 1'b1; enable_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst.OutA", a0, 32'h0);
      check("rst.OutB", b0, 32'h0);
      check("rst.valid_a", 32'(va0), 32'h0);
      check("rst.valid_b", 32'(vb0), 32'h0);
    end
    rst_n = 1'b1;
    address_a = 5'd9; address_b = 5'd17;
    tick();
    check("post_rst.OutA", a0, 32'h0);
    check("post_rst.valid_a", 32'(va0), 32'h1);

    // Write sweep then split read sweep
    idle();
    for (int i = 1; i < 32; i++) begin
      enable_w = 1'b1; address_w = 5'(i); In = 32'hA5A50000 + 32'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      enable_a = 1'b1; address_a = 5'(i);
      enable_b = 1'b1; address_b = 5'(16 + i);
      tick();
      check("sweep.dflt.A", a0, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
      check("sweep.dflt.B", b0, 32'hA5A50000 + 32'(16 + i));
      check("sweep.alt.A", a1, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
      check("sweep.alt.B", b1, (16 + i < 20) ? 32'hA5A50000 + 32'(16 + i) : 32'h0);
    end

    // Bypass vs no bypass
    idle();
    enable_w = 1'b1; address_w = 5'd5; In = 32'h11111111;
    tick();
    In = 32'h22222222; enable_a = 1'b1; address_a = 5'd5;
    tick();
    check("byp.dflt", a0, 32'h22222222);
    check("byp.alt", a1, 32'h11111111);
    enable_w = 1'b0;
    tick();
    check("byp_next.dflt", a0, 32'h22222222);
    check("byp_next.alt", a1, 32'h22222222);

    // Clear beats write
    idle();
    enable_w = 1'b1; address_w = 5'd7; In = 32'hDEADBEEF;
    tick();
    clear = 1'b1; In = 32'h12345678;
    enable_a = 1'b1; address_a = 5'd7; enable_b = 1'b1; address_b = 5'd5;
    tick();
    check("clr_same.dflt", a0, 32'h0);
    check("clr_same.alt", a1, 32'h0);
    check("clr_same.dfltB", b0, 32'h0);
    clear = 1'b0; enable_w = 1'b0;
    tick();
    check("clr_next.dflt", a0, 32'h0);
    check("clr_next.alt", a1, 32'h0);
    check("clr_next.dfltB", b0, 32'h0);

    // Out-of-range write/read and hold
    idle();
    enable_w = 1'b1; address_w = 5'd25; In = 32'hFFFFFFFF;
    tick();
    enable_w = 1'b0; enable_a = 1'b1; address_a = 5'd25;
    tick();
    check("oor.alt", a1, 32'h0);
    check("oor.dflt", a0, 32'hFFFFFFFF);
    enable_a = 1'b0; address_a = 5'd1;
    tick();
    check("hold.dflt", a0, 32'hFFFFFFFF);
    check("hold.valid_a", 32'(va0), 32'h0);

    // Mid-operation reset discards the in-flight write
    idle();
    enable_w = 1'b1; address_w = 5'd3; In = 32'h00000033;
    tick();
    enable_w = 1'b0; enable_a = 1'b1; address_a = 5'd3;
    tick();
    check("pre_rst.dflt", a0, 32'h00000033);
    enable_w = 1'b1; In = 32'hCAFEF00D;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.dflt.A", a0, 32'h0);
    check("mid_rst.valid_a", 32'(va0), 32'h0);
    check("mid_rst.alt.A", a1, 32'h0);
    tick();
    rst_n = 1'b1; enable_w = 1'b0;
    tick();
    check("after_rst.dflt", a0, 32'h0);
    check("after_rst.alt", a1, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      clear     = ($urandom_range(31) == 0);
      enable_w  = ($urandom_range(3) != 0);
      address_w = 5'($urandom_range(31));
      In        = $urandom;
      enable_a  = ($urandom_range(3) != 0);
      address_a = ($urandom_range(2) == 0) ? address_w : 5'($urandom_range(31));
      enable_b  = ($urandom_range(3) != 0);
      address_b = ($urandom_range(2) == 0) ? address_a : 5'($urandom_range(31));
      if ($urandom_range(299) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
